// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave register file: FSM states, command
// byte layout and frame geometry.
package spi_pkg;

  // Frame-level FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    DATA    = 3'd2,
    DONE    = 3'd3,
    WAIT_SS = 3'd4
  } state_t;

  // Command byte: bit7 = write flag, bits2:0 = register address.
  localparam int CMD_W_BIT  = 7;
  localparam int ADDR_W     = 3;
  localparam int CMD_BITS   = 8;
  localparam int FRAME_BITS = 16;
  localparam int NUM_REGS   = 8;

  // Bit counter is 5 bits wide and parks at the frame length.
  localparam logic [4:0] BIT_CNT_CMD_LAST  = 5'(CMD_BITS - 1);
  localparam logic [4:0] BIT_CNT_DATA_LAST = 5'(FRAME_BITS - 1);
  localparam logic [4:0] BIT_CNT_MAX       = 5'(FRAME_BITS);

  // Reset value of register n taken from the packed initialisation vector.
  function automatic logic [7:0] init_byte(input logic [63:0] init, input int idx);
    return init[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between the team's SPI master and this slave endpoint.
interface spi_slave_regfile_if;
  logic SCLK;
  logic SS;
  logic MOSI_bit;
  logic MISO_bit;

  modport master (
    output SCLK,
    output SS,
    output MOSI_bit,
    input  MISO_bit
  );

  modport slave (
    input  SCLK,
    input  SS,
    input  MOSI_bit,
    output MISO_bit
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level. The chain resets to
// 0 so that a slave select still held low across a reset does not look like
// a fresh falling edge once reset is released.
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_r;
  logic              prev_r;

  // Shift the pin through the synchronizer and keep one older sample for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= '0;
      prev_r  <= 1'b0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], din};
      prev_r  <= chain_r[STAGES-1];
    end
  end

  assign level = chain_r[STAGES-1];
  assign rise  = chain_r[STAGES-1] & ~prev_r;
  assign fall  = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave with an 8 x 8-bit register file. Each 16-bit frame is a
// command byte (W flag + 3-bit address) followed by one data byte. All SPI
// pins are oversampled in the clk_50M domain.
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter logic [63:0] REG_INIT    = 64'h0000_0000_0000_0000,
  parameter logic [7:0]  DEV_ID      = 8'hA5,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk_50M,
  input  logic                  reset,
  spi_slave_regfile_if.slave    spi,
  output logic                  wr_strobe,
  output logic                  frame_done,
  output logic [ADDR_W-1:0]     last_addr,
  output logic [7:0]            last_data
);

  // Synchronized pin views.
  logic sclk_lvl_s;
  logic sclk_rise_s;
  logic sclk_fall_s;
  logic ss_lvl_s;
  logic ss_rise_unused;
  logic ss_fall_s;
  logic mosi_lvl_s;
  logic mosi_rise_unused;
  logic mosi_fall_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (clk_50M),
    .rst_n (reset),
    .din   (spi.SCLK),
    .level (sclk_lvl_s),
    .rise  (sclk_rise_s),
    .fall  (sclk_fall_s)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk   (clk_50M),
    .rst_n (reset),
    .din   (spi.SS),
    .level (ss_lvl_s),
    .rise  (ss_rise_unused),
    .fall  (ss_fall_s)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (clk_50M),
    .rst_n (reset),
    .din   (spi.MOSI_bit),
    .level (mosi_lvl_s),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // Frame state.
  state_t              state_r;
  logic [4:0]          bit_cnt_r;
  logic [4:0]          bit_cnt_inc_s;
  // Only the first seven command bits are stored; the eighth is taken
  // straight from MOSI on the rise that completes the command byte.
  logic [6:0]          cmd_sr_r;
  logic [ADDR_W-1:0]   cmd_addr_s;
  logic [ADDR_W-1:0]   addr_r;
  logic                w_r;
  logic [7:0]          tx_sr_r;
  logic [7:0]          rx_sr_r;
  logic [7:0]          rd_byte_r;
  logic [7:0]          rd_byte_s;
  logic                miso_r;
  logic                wr_strobe_r;
  logic                frame_done_r;
  logic [ADDR_W-1:0]   last_addr_r;
  logic [7:0]          last_data_r;
  logic [7:0]          regs_r [1:NUM_REGS-1];

  // Address being formed on the final command-bit rise.
  assign cmd_addr_s = {cmd_sr_r[ADDR_W-2:0], mosi_lvl_s};

  // Saturating bit counter increment, so extra SCLK cycles never wrap it.
  assign bit_cnt_inc_s = (bit_cnt_r < BIT_CNT_MAX) ? (bit_cnt_r + 5'd1) : bit_cnt_r;

  // Read mux: address 0 is the read-only device ID, others come from the file.
  always_comb begin
    rd_byte_s = DEV_ID;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (cmd_addr_s == ADDR_W'(i)) begin
        rd_byte_s = regs_r[i];
      end else begin
        rd_byte_s = rd_byte_s;
      end
    end
  end

  // Frame FSM, shift registers, register file and all registered outputs.
  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 5'd0;
      cmd_sr_r     <= 7'd0;
      addr_r       <= '0;
      w_r          <= 1'b0;
      tx_sr_r      <= 8'd0;
      rx_sr_r      <= 8'd0;
      rd_byte_r    <= 8'd0;
      miso_r       <= 1'b0;
      wr_strobe_r  <= 1'b0;
      frame_done_r <= 1'b0;
      last_addr_r  <= '0;
      last_data_r  <= 8'd0;
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_r[i] <= init_byte(REG_INIT, i);
      end
    end else begin
      wr_strobe_r  <= 1'b0;
      frame_done_r <= 1'b0;
      if (ss_lvl_s) begin
        // Deselected: abandon any partial frame; SS beats a coincident SCLK edge.
        state_r   <= IDLE;
        bit_cnt_r <= 5'd0;
        miso_r    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            miso_r <= 1'b0;
            if (ss_fall_s) begin
              bit_cnt_r <= 5'd0;
              state_r   <= CMD;
            end else begin
              state_r <= IDLE;
            end
          end
          CMD: begin
            if (sclk_rise_s) begin
              cmd_sr_r  <= {cmd_sr_r[5:0], mosi_lvl_s};
              bit_cnt_r <= bit_cnt_inc_s;
              if (bit_cnt_r == BIT_CNT_CMD_LAST) begin
                addr_r  <= cmd_addr_s;
                w_r     <= cmd_sr_r[CMD_W_BIT-1];
                state_r <= DATA;
                if (!cmd_sr_r[CMD_W_BIT-1]) begin
                  tx_sr_r   <= rd_byte_s;
                  rd_byte_r <= rd_byte_s;
                  miso_r    <= rd_byte_s[7];
                end else begin
                  miso_r <= 1'b0;
                end
              end else begin
                state_r <= CMD;
              end
            end else begin
              state_r <= CMD;
            end
          end
          DATA: begin
            if (w_r) begin
              miso_r <= 1'b0;
              if (sclk_rise_s) begin
                rx_sr_r <= {rx_sr_r[6:0], mosi_lvl_s};
              end else begin
                rx_sr_r <= rx_sr_r;
              end
            end else if (sclk_fall_s) begin
              // MISO presents the current MSB, then the shifter advances.
              miso_r  <= tx_sr_r[7];
              tx_sr_r <= {tx_sr_r[6:0], 1'b0};
            end else begin
              miso_r <= miso_r;
            end
            if (sclk_rise_s) begin
              bit_cnt_r <= bit_cnt_inc_s;
              if (bit_cnt_r == BIT_CNT_DATA_LAST) begin
                state_r <= DONE;
              end else begin
                state_r <= DATA;
              end
            end else begin
              state_r <= DATA;
            end
          end
          DONE: begin
            miso_r       <= 1'b0;
            frame_done_r <= 1'b1;
            last_addr_r  <= addr_r;
            if (w_r) begin
              wr_strobe_r <= 1'b1;
              last_data_r <= rx_sr_r;
              // Address 0 is read-only: the strobe still fires, storage does not.
              for (int i = 1; i < NUM_REGS; i++) begin
                if (addr_r == ADDR_W'(i)) begin
                  regs_r[i] <= rx_sr_r;
                end else begin
                  regs_r[i] <= regs_r[i];
                end
              end
            end else begin
              last_data_r <= rd_byte_r;
            end
            state_r <= WAIT_SS;
          end
          WAIT_SS: begin
            miso_r  <= 1'b0;
            state_r <= WAIT_SS;
          end
          default: begin
            miso_r  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign spi.MISO_bit = miso_r;
  assign wr_strobe    = wr_strobe_r;
  assign frame_done   = frame_done_r;
  assign last_addr    = last_addr_r;
  assign last_data    = last_data_r;

endmodule
